// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: instruction sequencer for the PC register, the 16-bit IR
// and the reg8_8 register file. It clears PC on start and fetches each
// instruction as two byte reads (low, then high) over a req/ack bus. It then
// decodes the IR and issues one register-file operation per instruction.
module fetch_exec_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_ack,
  input  logic [15:0] irout,
  output logic        mem_req,
  output logic        pc_enable,
  output logic [1:0]  pc_funsel,
  output logic        ir_enable,
  output logic [1:0]  ir_funsel,
  output logic        ir_lh,
  output logic [1:0]  rf_funsel,
  output logic [3:0]  rf_rsel,
  output logic [3:0]  rf_tsel,
  output logic [2:0]  rf_o1sel,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLRPC   = 3'd1,
    S_FETCH_L = 3'd2,
    S_FETCH_H = 3'd3,
    S_DECODE  = 3'd4,
    S_EXEC    = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDR  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_OUT  = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Last unacknowledged request cycle before the bus is declared dead.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  // Instruction fields.
  logic [2:0] ir_op;
  logic [2:0] ir_dst;
  logic [2:0] ir_src;
  logic       unused_irout;

  assign ir_op        = irout[15:13];
  assign ir_dst       = irout[12:10];
  assign ir_src       = irout[9:7];
  assign unused_irout = ^irout[6:0];

  // One-hot destination decode. Bits 3:0 are the R registers and bits 7:4
  // are the T registers.
  logic [7:0] dst_hot;
  for (genvar gi = 0; gi < 8; gi++) begin : g_dst
    assign dst_hot[gi] = (ir_dst == 3'(gi));
  end

  state_t            state_q,     state_d;
  logic [WAIT_W-1:0] wait_q,      wait_d;
  logic [2:0]        op_q,        op_d;
  logic              bus_err_q,   bus_err_d;
  logic              mem_req_q,   mem_req_d;
  logic              pc_clr_q,    pc_clr_d;
  logic [1:0]        pc_funsel_q, pc_funsel_d;
  logic [1:0]        ir_funsel_q, ir_funsel_d;
  logic              ir_lh_q,     ir_lh_d;
  logic [1:0]        rf_funsel_q, rf_funsel_d;
  logic [3:0]        rf_rsel_q,   rf_rsel_d;
  logic [3:0]        rf_tsel_q,   rf_tsel_d;
  logic [2:0]        rf_o1sel_q,  rf_o1sel_d;
  logic              busy_q,      busy_d;
  logic              halted_q,    halted_d;
  logic              illegal_q,   illegal_d;
  logic              fetch_d;

  // Next state, wait counter, captured opcode and sticky bus error.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLRPC;
          bus_err_d = 1'b0;
        end
      end
      S_CLRPC: begin
        state_d = S_FETCH_L;
        wait_d  = '0;
      end
      S_FETCH_L, S_FETCH_H: begin
        if (mem_ack) begin
          state_d = (state_q == S_FETCH_L) ? S_FETCH_H : S_DECODE;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d    = ir_op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = (op_q == OP_HALT) ? S_HALT : S_FETCH_L;
        wait_d  = '0;
      end
      S_HALT: begin
        if (start) begin
          state_d   = S_CLRPC;
          bus_err_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Registered outputs are computed from the upcoming state. Register-file
  // controls are decoded from irout while in DECODE, so they appear during
  // EXEC.
  always_comb begin
    fetch_d     = (state_d == S_FETCH_L) || (state_d == S_FETCH_H);
    mem_req_d   = fetch_d;
    ir_funsel_d = fetch_d ? FS_LOAD : FS_CLR;
    ir_lh_d     = (state_d == S_FETCH_H);
    pc_clr_d    = (state_d == S_CLRPC);
    pc_funsel_d = fetch_d ? FS_INC : FS_CLR;
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d    = (state_d == S_HALT);
    rf_funsel_d = FS_CLR;
    rf_rsel_d   = '0;
    rf_tsel_d   = '0;
    rf_o1sel_d  = rf_o1sel_q;
    illegal_d   = 1'b0;
    if (state_q == S_DECODE) begin
      case (ir_op)
        OP_CLR: begin
          rf_funsel_d = FS_CLR;
          rf_rsel_d   = dst_hot[3:0];
          rf_tsel_d   = dst_hot[7:4];
        end
        OP_LDR: begin
          rf_funsel_d = FS_LOAD;
          rf_rsel_d   = dst_hot[3:0];
          rf_tsel_d   = dst_hot[7:4];
        end
        OP_DEC: begin
          rf_funsel_d = FS_DEC;
          rf_rsel_d   = dst_hot[3:0];
          rf_tsel_d   = dst_hot[7:4];
        end
        OP_INC: begin
          rf_funsel_d = FS_INC;
          rf_rsel_d   = dst_hot[3:0];
          rf_tsel_d   = dst_hot[7:4];
        end
        OP_OUT:  rf_o1sel_d = ir_src;
        OP_ILL:  illegal_d  = 1'b1;
        OP_NOP, OP_HALT: ;
        default: ;
      endcase
    end
  end

  // All state and output flops. Asynchronous reset drops every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      op_q        <= OP_NOP;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      pc_clr_q    <= 1'b0;
      pc_funsel_q <= FS_CLR;
      ir_funsel_q <= FS_CLR;
      ir_lh_q     <= 1'b0;
      rf_funsel_q <= FS_CLR;
      rf_rsel_q   <= '0;
      rf_tsel_q   <= '0;
      rf_o1sel_q  <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      op_q        <= op_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      pc_clr_q    <= pc_clr_d;
      pc_funsel_q <= pc_funsel_d;
      ir_funsel_q <= ir_funsel_d;
      ir_lh_q     <= ir_lh_d;
      rf_funsel_q <= rf_funsel_d;
      rf_rsel_q   <= rf_rsel_d;
      rf_tsel_q   <= rf_tsel_d;
      rf_o1sel_q  <= rf_o1sel_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  // The byte-capture enables follow mem_ack in the same cycle. They are
  // gated by mem_req_q, which is high only while fetching.
  assign mem_req   = mem_req_q;
  assign ir_enable = mem_req_q & mem_ack;
  assign pc_enable = pc_clr_q | (mem_req_q & mem_ack);
  assign pc_funsel = pc_funsel_q;
  assign ir_funsel = ir_funsel_q;
  assign ir_lh     = ir_lh_q;
  assign rf_funsel = rf_funsel_q;
  assign rf_rsel   = rf_rsel_q;
  assign rf_tsel   = rf_tsel_q;
  assign rf_o1sel  = rf_o1sel_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

endmodule
